// File: rtl/lif_array.sv
// Array of N leaky integrate-and-fire neurons stepped in lockstep.
// Each neuron has its own potential, refractory counter and writable threshold.
// Spikes from one step appear as a registered vector on the following cycle.
module lif_array #(
  parameter int N          = 4,
  parameter int WIDTH      = 16,
  parameter int IN_WIDTH   = 8,
  parameter int THRESHOLD  = 100,
  parameter int DECAY      = 1,
  parameter int LEAK_SHIFT = 4,
  parameter int LEAK_MODE  = 0,
  parameter int RESET_MODE = 0,
  parameter int REF_PERIOD = 10,
  localparam int AW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step,
  input  logic [N*IN_WIDTH-1:0]    in_current,
  input  logic                     thr_wr_en,
  input  logic [AW-1:0]            thr_wr_addr,
  input  logic [WIDTH-1:0]         thr_wr_data,
  input  logic [AW-1:0]            v_rd_addr,
  output logic [WIDTH-1:0]         v_rd_data,
  output logic [N-1:0]             spike,
  output logic                     spike_valid
);

  // Three guard bits cover V + I - L and V_next - thr without wrap-around.
  localparam int EW = WIDTH + 3;
  localparam int RW = (REF_PERIOD > 0) ? $clog2(REF_PERIOD + 1) : 1;
  localparam logic signed [EW-1:0] VMAX = EW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] VMIN = -VMAX - EW'(1);

  logic signed [WIDTH-1:0] v       [N];
  logic signed [WIDTH-1:0] thr     [N];
  logic [RW-1:0]           ref_cnt [N];

  logic signed [WIDTH-1:0] v_upd   [N];
  logic [RW-1:0]           ref_upd [N];
  logic [N-1:0]            fire;

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [EW-1:0] x);
    if (x > VMAX) return VMAX[WIDTH-1:0];
    if (x < VMIN) return VMIN[WIDTH-1:0];
    return x[WIDTH-1:0];
  endfunction

  // Per-neuron next state for a step: integrate, leak, threshold, refractory.
  always_comb begin
    logic signed [EW-1:0]    vx;
    logic signed [EW-1:0]    cur;
    logic signed [EW-1:0]    leak;
    logic signed [WIDTH-1:0] vn;
    vx   = '0;
    cur  = '0;
    leak = '0;
    vn   = '0;
    fire = '0;
    for (int i = 0; i < N; i++) begin
      v_upd[i]   = v[i];
      ref_upd[i] = ref_cnt[i];
      if (ref_cnt[i] != '0) begin
        ref_upd[i] = ref_cnt[i] - RW'(1);
      end else begin
        vx   = EW'(v[i]);
        cur  = EW'($signed(in_current[i*IN_WIDTH +: IN_WIDTH]));
        leak = (LEAK_MODE != 0) ? EW'(v[i] >>> LEAK_SHIFT) : EW'(DECAY);
        vn   = sat(vx + cur - leak);
        if (vn >= thr[i]) begin
          fire[i]    = 1'b1;
          v_upd[i]   = (RESET_MODE != 0) ? sat(EW'(vn) - EW'(thr[i])) : '0;
          ref_upd[i] = RW'(REF_PERIOD);
        end else begin
          v_upd[i] = vn;
        end
      end
    end
  end

  // State update, threshold writes, registered read port and spike output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        v[i]       <= '0;
        ref_cnt[i] <= '0;
        thr[i]     <= WIDTH'(THRESHOLD);
      end
      spike       <= '0;
      spike_valid <= 1'b0;
      v_rd_data   <= '0;
    end else begin
      if (step) begin
        for (int i = 0; i < N; i++) begin
          v[i]       <= v_upd[i];
          ref_cnt[i] <= ref_upd[i];
        end
      end
      // The step above compares against thr before this write lands.
      if (thr_wr_en && (int'(thr_wr_addr) < N)) begin
        thr[thr_wr_addr] <= thr_wr_data;
      end
      spike       <= step ? fire : '0;
      spike_valid <= step;
      v_rd_data   <= (int'(v_rd_addr) < N) ? v[v_rd_addr] : '0;
    end
  end

endmodule
